dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 7 +
 rtl/rr_arb2.sv | 11 +
 rtl/dmem_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states, port ids and memory size for the data-memory arbiter.
package dmem_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
    localparam int MEM_WORDS_DEFAULT = 256;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; a tie goes to the port that did not win last.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);
    assign o_gnt = {i_req[1] & (~i_req[0] | (i_last == PORT0)),
                    i_req[0] & (~i_req[1] | (i_last == PORT1))};
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between a core port and a debug/DMA port,
// one transaction at a time through IDLE -> ACCESS -> RESP.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    state_t      r_state, w_next;
    logic        r_last, r_port, r_we, r_err;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [1:0]  w_arb, w_gnt;
    logic        w_accept, w_sel, w_we, w_err, w_access, w_resp;
    logic [31:0] w_addr, w_wdata;

    rr_arb2 u_rr (
        .i_req  ({p1_req, p0_req}),
        .i_last (r_last),
        .o_gnt  (w_arb)
    );

    // Everything visible is gated by rst_n so a reset kills grants, writes and responses at once.
    always_comb begin
        w_gnt    = (rst_n && r_state == S_IDLE) ? w_arb : 2'b00;
        w_accept = |w_gnt;
        w_sel    = w_gnt[1] ? PORT1 : PORT0;
        w_we     = w_gnt[1] ? p1_we : p0_we;
        w_addr   = w_gnt[1] ? p1_addr : p0_addr;
        w_wdata  = w_gnt[1] ? p1_wdata : p0_wdata;
        w_err    = (w_addr[1:0] != 2'b00) || ({2'b00, w_addr[31:2]} >= 32'(MEM_WORDS));
        w_next   = (r_state == S_IDLE) ? (w_accept ? S_ACCESS : S_IDLE) :
                   (r_state == S_ACCESS) ? S_RESP : S_IDLE;
        w_access = rst_n && r_state == S_ACCESS;
        w_resp   = rst_n && r_state == S_RESP;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= PORT1;
            r_port  <= PORT0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_last  <= w_sel;
                r_port  <= w_sel;
                r_we    <= w_we;
                r_err   <= w_err;
                r_addr  <= w_addr;
                r_wdata <= w_wdata;
            end
            if (r_state == S_ACCESS)
                r_rdata <= (!r_err && !r_we) ? mem_rdata : '0;
        end
    end

    assign p0_gnt    = w_gnt[0];
    assign p1_gnt    = w_gnt[1];
    assign mem_read  = w_access & ~r_err & ~r_we;
    assign mem_write = w_access & ~r_err & r_we;
    assign mem_addr  = w_access ? r_addr : '0;
    assign mem_wdata = w_access ? r_wdata : '0;
    assign p0_rvalid = w_resp && r_port == PORT0;
    assign p1_rvalid = w_resp && r_port == PORT1;
    assign p0_rdata  = p0_rvalid ? r_rdata : '0;
    assign p1_rdata  = p1_rvalid ? r_rdata : '0;
    assign p0_err    = p0_rvalid & r_err;
    assign p1_err    = p1_rvalid & r_err;
endmodule
